// File: rtl/riscv_pkg.sv
// Shared RV32 execute-stage definitions: M-extension funct3 encodings,
// divider FSM states and the divider's special-case result constants.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;
  localparam logic [XLEN-1:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {acc, quo} left, trial-subtract the
// divisor and keep the difference only when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The shifted partial remainder is below 2*divisor, so bit WIDTH of the
  // difference is a reliable sign bit.
  assign shifted  = {acc, quo[WIDTH-1]};
  assign trial    = shifted - {1'b0, divisor};
  assign acc_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per clock.
// state | meaning
// IDLE  | waiting for start with funct3[2]=1
// CALC  | restoring iterations, counter WIDTH-1 down to 0
// DONE  | single-cycle result strobe to the register file write port
module div_unit
  import riscv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1Data,
  input  logic [WIDTH-1:0] rs2Data,
  input  logic [4:0]       rdIn,
  output logic             busy,
  output logic             done,
  output logic             writeEnable,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rdOut
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONE = WIDTH'(DIV_BY_ZERO_Q);

  div_state_t state, state_next;

  logic [WIDTH-1:0] acc, quo, dvsr, res_q;
  logic [WIDTH-1:0] acc_nx, quo_nx;
  logic [WIDTH-1:0] q_fix, r_fix, final_val;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       rd_cap, rd_q;
  logic             rem_sel, neg_q, neg_r;

  logic accept, is_signed, a_neg, b_neg, div_zero, overflow, special, last;

  assign accept    = (state == IDLE) && start && funct3[2] && !flush;
  assign is_signed = ~funct3[0];
  assign a_neg     = is_signed & rs1Data[WIDTH-1];
  assign b_neg     = is_signed & rs2Data[WIDTH-1];
  assign div_zero  = (rs2Data == '0);
  assign overflow  = is_signed && (rs1Data == MIN_NEG) && (rs2Data == ALL_ONE);
  assign special   = div_zero || overflow;
  assign last      = (state == CALC) && (cnt == '0) && !flush;

  div_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .quo      (quo),
    .divisor  (dvsr),
    .acc_next (acc_nx),
    .quo_next (quo_nx)
  );

  // Fix-up works on the final iteration's outputs so DONE needs no extra cycle.
  assign q_fix     = neg_q ? -quo_nx : quo_nx;
  assign r_fix     = neg_r ? -acc_nx : acc_nx;
  assign final_val = rem_sel ? r_fix : q_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: begin
        if (flush)           state_next = IDLE;
        else if (cnt == '0)  state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == CALC) || (state == DONE);
    done        = (state == DONE) && !flush;
    writeEnable = done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      cnt     <= '0;
      res_q   <= '0;
      rd_cap  <= '0;
      rd_q    <= '0;
      rem_sel <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (accept) begin
      rem_sel <= funct3[1];
      rd_cap  <= rdIn;
      if (special) begin
        rd_q <= rdIn;
        if (div_zero) res_q <= funct3[1] ? rs1Data : ALL_ONE;
        else          res_q <= funct3[1] ? '0 : MIN_NEG;
      end else begin
        acc   <= '0;
        quo   <= a_neg ? -rs1Data : rs1Data;
        dvsr  <= b_neg ? -rs2Data : rs2Data;
        cnt   <= CNT_W'(WIDTH - 1);
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
      end
    end else if ((state == CALC) && !flush) begin
      acc <= acc_nx;
      quo <= quo_nx;
      cnt <= cnt - CNT_W'(1);
      if (last) begin
        res_q <= final_val;
        rd_q  <= rd_cap;
      end
    end
  end

  assign result = res_q;
  assign rdOut  = rd_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed operations push expected results,
// a negedge monitor pops and compares whenever the unit strobes done.
module tb_div_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1Data = '0;
  logic [31:0] rs2Data = '0;
  logic [4:0]  rdIn = '0;
  logic        busy, done, writeEnable;
  logic [31:0] result;
  logic [4:0]  rdOut;

  div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .flush       (flush),
    .funct3      (funct3),
    .rs1Data     (rs1Data),
    .rs2Data     (rs2Data),
    .rdIn        (rdIn),
    .busy        (busy),
    .done        (done),
    .writeEnable (writeEnable),
    .result      (result),
    .rdOut       (rdOut)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;
  bit          has_last = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done || writeEnable) begin
      check("we_equals_done", {31'd0, writeEnable}, {31'd0, done});
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got result %h rd %0d expected no strobe (cycle %0d)",
                 result, rdOut, cyc);
      end else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("rd_out", {27'd0, rdOut}, {27'd0, e.rd});
        check("latency_cycle", cyc, e.cyc);
        last_res = e.res;
        last_rd  = e.rd;
        has_last = 1;
      end
    end
  end

  // Called at #1 after a rising edge; start is held for exactly one cycle.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit push, input logic [31:0] exp_res,
                       input int lat, output int c);
    exp_t e;
    funct3 = f3; rs1Data = a; rs2Data = b; rdIn = rd; start = 1'b1;
    c = cyc;
    if (push) begin
      e.res = exp_res; e.rd = rd; e.cyc = c + lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    bit ok = 0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy %0b pending %0d expected idle within %0d cycles",
               busy, sb.size(), max_cycles);
      sb.delete();
    end else if (has_last) begin
      check("result_hold", result, last_res);
      check("rd_hold", {27'd0, rdOut}, {27'd0, last_rd});
    end
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res, input int lat);
    int c;
    issue(f3, a, b, rd, 1, exp_res, lat, c);
    wait_idle(60);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_we", {31'd0, writeEnable}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd", {27'd0, rdOut}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(F3_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33);
    run_op(F3_REMU, 32'd100, 32'd7, 5'd6, 32'd2, 33);
    run_op(F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 33);
    run_op(F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 33);
    run_op(F3_REM, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'd1, 33);
    run_op(F3_DIV, 32'd7, 32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD, 33);
    run_op(F3_DIVU, 32'hFFFF_FFFF, 32'd16, 5'd11, 32'h0FFF_FFFF, 33);

    run_op(F3_DIVU, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1);
    run_op(F3_REMU, 32'd5, 32'd0, 5'd13, 32'd5, 1);
    run_op(F3_DIV, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, 1);
    run_op(F3_REM, 32'hFFFF_FFFB, 32'd0, 5'd15, 32'hFFFF_FFFB, 1);
    run_op(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1);
    run_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 1);
    run_op(F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0, 33);

    // Second start while busy must be ignored.
    issue(F3_DIVU, 32'd1000, 32'd3, 5'd19, 1, 32'd333, 33, c);
    goto(c + 10);
    funct3 = F3_DIVU; rs1Data = 32'd50; rs2Data = 32'd5; rdIn = 5'd20; start = 1'b1;
    @(negedge clk);
    check("busy_mid_calc", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    goto(c + 33);
    @(negedge clk);
    check("busy_in_done", {31'd0, busy}, 32'd1);
    wait_idle(60);

    // Flush mid-calculation, then restart two cycles later.
    issue(F3_DIVU, 32'd77, 32'd7, 5'd21, 0, 32'd0, 0, c);
    goto(c + 15);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("busy_after_flush", {31'd0, busy}, 32'd0);
    goto(c + 17);
    run_op(F3_DIVU, 32'd77, 32'd7, 5'd3, 32'd11, 33);

    // Flush coinciding with DONE suppresses the strobe.
    issue(F3_DIVU, 32'd5, 32'd0, 5'd22, 0, 32'd0, 0, c);
    flush = 1'b1;
    @(negedge clk);
    check("flush_done_suppressed", {31'd0, done}, 32'd0);
    check("flush_we_suppressed", {31'd0, writeEnable}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    has_last = 0;

    // Flush together with start in IDLE: nothing accepted.
    funct3 = F3_DIVU; rs1Data = 32'd9; rs2Data = 32'd3; rdIn = 5'd23;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_ignored", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Non-divide funct3 is ignored.
    issue(3'b000, 32'd9, 32'd3, 5'd24, 0, 32'd0, 0, c);
    @(negedge clk);
    check("non_div_ignored", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    run_op(F3_REMU, 32'd1234, 32'd100, 5'd25, 32'd34, 33);

    // Asynchronous reset mid-operation.
    issue(F3_DIV, 32'hFFFF_FF9C, 32'd7, 5'd26, 0, 32'd0, 0, c);
    goto(c + 20);
    rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_we", {31'd0, writeEnable}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd", {27'd0, rdOut}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    has_last = 0;
    @(posedge clk); #1;
    run_op(F3_DIVU, 32'd9, 32'd3, 5'd4, 32'd3, 33);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
